// File: rtl/otp_fetch_ctrl.sv
// otp_fetch_ctrl: instruction-fetch requester for the OTP program memory.
// It issues one OTP word read per cycle while buffer credit is available.
// It captures the registered read data one cycle later and queues
// {pc, instr} pairs in a prefetch FIFO that feeds decode over valid/ready.
// A redirect pulse flushes both buffered and in-flight words.
// Optional feature macro: OTP_FETCH_BYPASS_EN. When it is defined, a
// response that arrives while the FIFO is empty is presented to decode in
// the same cycle.
module otp_fetch_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] otp_pa,
  output logic        otp_en,
  input  logic [31:0] otp_rdata,
  output logic        ifu_valid,
  output logic [31:0] ifu_instr,
  output logic [31:0] ifu_pc,
  input  logic        ifu_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] RESET_PC_W = RESET_PC & ~32'h3;

  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic          resp_pending;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [CW-1:0] credit_used;
  logic          fifo_empty;
  logic          issue;
  logic          push;
  logic          pop;

  // Issue decision: an outstanding response already owns a slot. A pop in
  // the same cycle gives no credit back. Reset gates the request off.
  always_comb begin
    credit_used = count + CW'(resp_pending);
    fifo_empty  = (count == '0);
    issue       = rst_n & fetch_enable & ~redirect_valid & (credit_used < DEPTH_C);
    otp_en      = issue;
    otp_pa      = fetch_pc;
  end

`ifdef OTP_FETCH_BYPASS_EN
  logic bypass;

  // Decode-side view: an empty FIFO forwards the arriving OTP word directly.
  // The in-flight word is suppressed during a redirect so a dropped word is
  // never visible.
  always_comb begin
    bypass    = fifo_empty & resp_pending & ~redirect_valid;
    ifu_valid = ~fifo_empty | bypass;
    ifu_instr = bypass ? otp_rdata  : fifo_instr[rd_ptr];
    ifu_pc    = bypass ? pending_pc : fifo_pc[rd_ptr];
    pop       = ~fifo_empty & ifu_ready;
    push      = resp_pending & ~redirect_valid & ~(bypass & ifu_ready);
  end
`else
  // Decode-side view: only the FIFO head is ever presented.
  always_comb begin
    ifu_valid = ~fifo_empty;
    ifu_instr = fifo_instr[rd_ptr];
    ifu_pc    = fifo_pc[rd_ptr];
    pop       = ~fifo_empty & ifu_ready;
    push      = resp_pending & ~redirect_valid;
  end
`endif

  // Fetch PC and in-flight tracking. resp_pending follows issue directly,
  // because every response is consumed in the cycle after its request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC_W;
      pending_pc   <= '0;
      resp_pending <= 1'b0;
    end else begin
      resp_pending <= issue;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h3;
      end else if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd4;
      end
    end
  end

  // Prefetch FIFO storage, pointers and occupancy. A redirect flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= pending_pc;
        fifo_instr[wr_ptr] <= otp_rdata;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_fetch_ctrl.sv
// tb_otp_fetch_ctrl: directed test of otp_fetch_ctrl in its default build
// (FIFO_DEPTH=4, RESET_PC=0). The OTP model returns 0x100 + word index.
module tb_otp_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] otp_pa;
  logic        otp_en;
  logic [31:0] otp_rdata = '0;
  logic        ifu_valid;
  logic [31:0] ifu_instr;
  logic [31:0] ifu_pc;
  logic        ifu_ready;

  int vectors = 0;
  int miscompares = 0;

  otp_fetch_ctrl #(.FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_enable(fetch_enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .otp_pa(otp_pa), .otp_en(otp_en), .otp_rdata(otp_rdata),
    .ifu_valid(ifu_valid), .ifu_instr(ifu_instr), .ifu_pc(ifu_pc),
    .ifu_ready(ifu_ready)
  );

  always #5 clk = ~clk;

  // OTP memory model: registers the read word on an enabled edge and holds it otherwise.
  always @(posedge clk) if (otp_en) otp_rdata <= 32'h100 + (otp_pa >> 2);

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h100 + (pc >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input logic en, input logic [31:0] pa);
    chk({tag, "_en"}, {31'b0, otp_en}, {31'b0, en});
    chk({tag, "_pa"}, otp_pa, pa);
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, ifu_valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_pc"}, ifu_pc, pc);
      chk({tag, "_instr"}, ifu_instr, mem_word(pc));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_en"}, {31'b0, otp_en}, 32'd0);
    chk({tag, "_pa"}, otp_pa, 32'd0);
    chk({tag, "_valid"}, {31'b0, ifu_valid}, 32'd0);
    chk({tag, "_instr"}, ifu_instr, 32'd0);
    chk({tag, "_pc"}, ifu_pc, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fetch_enable = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; ifu_ready = 1'b1;

    // Reset state. fetch_enable is high, so otp_en must still be gated off.
    repeat (2) @(negedge clk);
    #1 check_reset("rst");

    // Streaming from RESET_PC with decode always ready.
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) @(negedge clk);
      #1;
      check_fetch($sformatf("stream%0d", n), 1'b1, 32'(4 * (n - 1)));
      if (n >= 3) check_head($sformatf("stream%0d", n), 1'b1, 32'(4 * (n - 3)));
      else        check_head($sformatf("stream%0d", n), 1'b0, '0);
    end

    // Backpressure: the FIFO fills, issue stops, then resumes one cycle after ready rises.
    for (int n = 11; n <= 23; n++) begin
      @(negedge clk);
      ifu_ready = (n >= 17);
      #1;
      if (n <= 12)      check_fetch($sformatf("bp%0d", n), 1'b1, 32'(40 + 4 * (n - 11)));
      else if (n <= 17) check_fetch($sformatf("bp%0d", n), 1'b0, 32'd48);
      else              check_fetch($sformatf("bp%0d", n), 1'b1, 32'(48 + 4 * (n - 18)));
      if (n <= 17) check_head($sformatf("bp%0d", n), 1'b1, 32'd32);
      else         check_head($sformatf("bp%0d", n), 1'b1, 32'(32 + 4 * (n - 17)));
    end

    // Build 3 buffered words plus one in flight, then redirect to 0x22.
    @(negedge clk); ifu_ready = 1'b0; #1;
    check_fetch("pre_rd", 1'b1, 32'd72);
    check_head("pre_rd", 1'b1, 32'd60);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h22; #1;   // cycle C
    check_fetch("rd_c", 1'b0, 32'd76);
    check_head("rd_c", 1'b1, 32'd60);
    @(negedge clk); redirect_valid = 1'b0; ifu_ready = 1'b1; #1;       // C+1
    check_fetch("rd_c1", 1'b1, 32'h20);
    check_head("rd_c1", 1'b0, '0);
    @(negedge clk); #1;                                                // C+2
    check_fetch("rd_c2", 1'b1, 32'h24);
    check_head("rd_c2", 1'b0, '0);
    @(negedge clk); #1;                                                // C+3
    check_fetch("rd_c3", 1'b1, 32'h28);
    check_head("rd_c3", 1'b1, 32'h20);
    @(negedge clk); ifu_ready = 1'b0; #1;                              // C+4, then 2 buffered
    check_fetch("rd_c4", 1'b1, 32'h2C);
    check_head("rd_c4", 1'b1, 32'h24);

    // Asynchronous reset mid-stream with the FIFO half full.
    @(negedge clk); rst_n = 1'b0; ifu_ready = 1'b1; #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      if (n > 1) @(negedge clk);
      #1;
      check_fetch($sformatf("restart%0d", n), 1'b1, 32'(4 * (n - 1)));
      if (n == 3) check_head("restart3", 1'b1, 32'd0);
      else        check_head($sformatf("restart%0d", n), 1'b0, '0);
    end

    // fetch_enable low for 5 cycles: no issue, the FIFO drains, then sequential fetch resumes.
    for (int n = 4; n <= 8; n++) begin
      @(negedge clk); fetch_enable = 1'b0; #1;
      check_fetch($sformatf("fe_off%0d", n), 1'b0, 32'd12);
      if (n <= 5) check_head($sformatf("fe_off%0d", n), 1'b1, 32'(4 * (n - 3)));
      else        check_head($sformatf("fe_off%0d", n), 1'b0, '0);
    end
    @(negedge clk); fetch_enable = 1'b1; #1;
    check_fetch("fe_on1", 1'b1, 32'd12);
    check_head("fe_on1", 1'b0, '0);
    @(negedge clk); #1;
    check_fetch("fe_on2", 1'b1, 32'd16);
    check_head("fe_on2", 1'b0, '0);
    @(negedge clk); #1;
    check_fetch("fe_on3", 1'b1, 32'd20);
    check_head("fe_on3", 1'b1, 32'd12);

    // PC wrap: redirect to 0xFFFF_FFFE (low bits masked), then the next PC wraps to 0.
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
    check_fetch("wrap_c", 1'b0, 32'd24);
    @(negedge clk); redirect_valid = 1'b0; #1;
    check_fetch("wrap_c1", 1'b1, 32'hFFFF_FFFC);
    check_head("wrap_c1", 1'b0, '0);
    @(negedge clk); #1;
    check_fetch("wrap_c2", 1'b1, 32'h0000_0000);
    check_head("wrap_c2", 1'b0, '0);
    @(negedge clk); #1;
    check_fetch("wrap_c3", 1'b1, 32'h4);
    check_head("wrap_c3", 1'b1, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check_fetch("wrap_c4", 1'b1, 32'h8);
    check_head("wrap_c4", 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
